// File: rtl/le_prefix_coder_seq.sv
// Sequential low-entropy prefix coder.
// Keeps one growing symbol prefix per code slot and looks each extended prefix up
// in an external codebook. Matches are emitted as codewords. A flush dumps every
// non-empty prefix raw, one slot at a time.
module le_prefix_coder_seq #(
    parameter int NUM_CODES           = 16,
    parameter int CODEBOOK_LENGTH_MAX = 64,
    parameter int ENCODE_DATALENGTH   = 21,
    parameter int CW                  = $clog2(NUM_CODES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           sym_valid_i,
    output logic                           sym_ready_o,
    input  logic [3:0]                     sym_data_i,
    input  logic [CW-1:0]                  sym_code_i,
    input  logic                           flush_i,
    output logic                           flush_done_o,
    output logic [CW-1:0]                  lk_code_o,
    output logic [5:0]                     lk_cnt_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] lk_data_o,
    input  logic                           lk_match_i,
    input  logic [5:0]                     lk_length_i,
    input  logic [ENCODE_DATALENGTH-1:0]   lk_data_i,
    output logic                           cw_valid_o,
    input  logic                           cw_ready_i,
    output logic [6:0]                     cw_length_o,
    output logic [CODEBOOK_LENGTH_MAX-1:0] cw_data_o,
    output logic [CW-1:0]                  cw_code_o,
    output logic                           cw_flush_o,
    output logic                           ovf_o
);

    // A prefix that reaches this many symbols without a match is dropped.
    localparam logic [5:0]    NIB_MAX  = 6'(CODEBOOK_LENGTH_MAX / 4);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CODES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        EMIT,
        FSCAN,
        FEMIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [5:0]                     slot_cnt  [NUM_CODES];
    logic [CODEBOOK_LENGTH_MAX-1:0] slot_data [NUM_CODES];

    logic [CW-1:0]                  cur_code;
    logic [3:0]                     cur_sym;
    logic [CW-1:0]                  scan_idx;
    logic [5:0]                     app_cnt;
    logic [CODEBOOK_LENGTH_MAX-1:0] app_data;
    logic                           scan_last;
    logic                           scan_hit;

    // The first symbol of a prefix ends up most significant.
    assign app_cnt   = slot_cnt[cur_code] + 6'd1;
    assign app_data  = {slot_data[cur_code][CODEBOOK_LENGTH_MAX-5:0], cur_sym};
    assign scan_last = (scan_idx == LAST_IDX);
    assign scan_hit  = (slot_cnt[scan_idx] != 6'd0);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the handshake, lookup and flush-done outputs.
    always_comb begin
        state_d      = state_q;
        sym_ready_o  = 1'b0;
        lk_code_o    = '0;
        lk_cnt_o     = '0;
        lk_data_o    = '0;
        cw_valid_o   = 1'b0;
        flush_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                sym_ready_o = !flush_i;
                if (flush_i) begin
                    state_d = FSCAN;
                end else if (sym_valid_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                lk_code_o = cur_code;
                lk_cnt_o  = app_cnt;
                lk_data_o = app_data;
                state_d   = lk_match_i ? EMIT : IDLE;
            end
            EMIT: begin
                cw_valid_o = 1'b1;
                if (cw_ready_i) begin
                    state_d = IDLE;
                end
            end
            FSCAN: begin
                if (scan_hit) begin
                    state_d = FEMIT;
                end else if (scan_last) begin
                    flush_done_o = 1'b1;
                    state_d      = IDLE;
                end
            end
            FEMIT: begin
                cw_valid_o = 1'b1;
                if (cw_ready_i) begin
                    if (scan_last) begin
                        flush_done_o = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = FSCAN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slot storage, captured symbol, scan index and the registered codeword.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CODES; i++) begin
                slot_cnt[i]  <= '0;
                slot_data[i] <= '0;
            end
            cur_code    <= '0;
            cur_sym     <= '0;
            scan_idx    <= '0;
            cw_length_o <= '0;
            cw_data_o   <= '0;
            cw_code_o   <= '0;
            cw_flush_o  <= 1'b0;
            ovf_o       <= 1'b0;
        end else begin
            ovf_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (flush_i) begin
                        scan_idx <= '0;
                    end else if (sym_valid_i) begin
                        cur_code <= sym_code_i;
                        cur_sym  <= sym_data_i;
                    end
                end
                LOOKUP: begin
                    if (lk_match_i) begin
                        cw_length_o         <= {1'b0, lk_length_i};
                        cw_data_o           <= CODEBOOK_LENGTH_MAX'(lk_data_i);
                        cw_code_o           <= cur_code;
                        cw_flush_o          <= 1'b0;
                        slot_cnt[cur_code]  <= '0;
                        slot_data[cur_code] <= '0;
                    end else if (app_cnt == NIB_MAX) begin
                        ovf_o               <= 1'b1;
                        slot_cnt[cur_code]  <= '0;
                        slot_data[cur_code] <= '0;
                    end else begin
                        slot_cnt[cur_code]  <= app_cnt;
                        slot_data[cur_code] <= app_data;
                    end
                end
                FSCAN: begin
                    if (scan_hit) begin
                        cw_length_o <= 7'({slot_cnt[scan_idx], 2'b00});
                        cw_data_o   <= slot_data[scan_idx];
                        cw_code_o   <= scan_idx;
                        cw_flush_o  <= 1'b1;
                    end else if (!scan_last) begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                FEMIT: begin
                    if (cw_ready_i) begin
                        slot_cnt[scan_idx]  <= '0;
                        slot_data[scan_idx] <= '0;
                        if (!scan_last) begin
                            scan_idx <= scan_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_le_prefix_coder_seq.sv
// Directed bench for le_prefix_coder_seq using the b9 codebook on code 9.
module tb_le_prefix_coder_seq;

    logic        clk_i;
    logic        rst_i;
    logic        sym_valid_i;
    logic        sym_ready_o;
    logic [3:0]  sym_data_i;
    logic [3:0]  sym_code_i;
    logic        flush_i;
    logic        flush_done_o;
    logic [3:0]  lk_code_o;
    logic [5:0]  lk_cnt_o;
    logic [63:0] lk_data_o;
    logic        lk_match_i;
    logic [5:0]  lk_length_i;
    logic [20:0] lk_data_i;
    logic        cw_valid_o;
    logic        cw_ready_i;
    logic [6:0]  cw_length_o;
    logic [63:0] cw_data_o;
    logic [3:0]  cw_code_o;
    logic        cw_flush_o;
    logic        ovf_o;

    int checks;
    int failures;
    int words;
    int ovf_count;

    le_prefix_coder_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sym_valid_i  (sym_valid_i),
        .sym_ready_o  (sym_ready_o),
        .sym_data_i   (sym_data_i),
        .sym_code_i   (sym_code_i),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .lk_code_o    (lk_code_o),
        .lk_cnt_o     (lk_cnt_o),
        .lk_data_o    (lk_data_o),
        .lk_match_i   (lk_match_i),
        .lk_length_i  (lk_length_i),
        .lk_data_i    (lk_data_i),
        .cw_valid_o   (cw_valid_o),
        .cw_ready_i   (cw_ready_i),
        .cw_length_o  (cw_length_o),
        .cw_data_o    (cw_data_o),
        .cw_code_o    (cw_code_o),
        .cw_flush_o   (cw_flush_o),
        .ovf_o        (ovf_o)
    );

    // 10 ns clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // b9 codebook fragment: {F} -> 10'h3E8, {0,2,F} -> 15'h7FF0; every other prefix misses.
    always_comb begin
        lk_match_i  = 1'b0;
        lk_length_i = 6'd0;
        lk_data_i   = 21'd0;
        if (lk_code_o == 4'd9) begin
            if (lk_cnt_o == 6'd1 && lk_data_o == 64'hF) begin
                lk_match_i  = 1'b1;
                lk_length_i = 6'd10;
                lk_data_i   = 21'h3E8;
            end else if (lk_cnt_o == 6'd3 && lk_data_o == 64'h02F) begin
                lk_match_i  = 1'b1;
                lk_length_i = 6'd15;
                lk_data_i   = 21'h7FF0;
            end
        end
    end

    // Counts delivered codewords and overflow pulses, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (cw_valid_o && cw_ready_i) words++;
            if (ovf_o) ovf_count++;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] code, input logic [3:0] sym);
        int guard;
        sym_code_i  = code;
        sym_data_i  = sym;
        sym_valid_i = 1'b1;
        guard = 0;
        while (!sym_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        checkOutput("sym_accept_timeout", 64'(guard < 50), 64'd1);
        @(posedge clk_i);
        #1;
        sym_valid_i = 1'b0;
    endtask

    task automatic checkSlotsEmpty(input string tag);
        int total;
        total = 0;
        for (int k = 0; k < 16; k++) total += int'(dut.slot_cnt[k]);
        checkOutput(tag, 64'(total), 64'd0);
    endtask

    task automatic runTest1(input string pfx);
        int w0;
        w0 = words;
        applyStimulus(4'd9, 4'hF);
        @(negedge clk_i);
        checkOutput({pfx, "_lk_cnt"}, 64'(lk_cnt_o), 64'd1);
        checkOutput({pfx, "_lk_data"}, lk_data_o, 64'hF);
        checkOutput({pfx, "_lk_code"}, 64'(lk_code_o), 64'd9);
        checkOutput({pfx, "_early_valid"}, 64'(cw_valid_o), 64'd0);
        @(negedge clk_i);
        checkOutput({pfx, "_valid"}, 64'(cw_valid_o), 64'd1);
        checkOutput({pfx, "_length"}, 64'(cw_length_o), 64'd10);
        checkOutput({pfx, "_data"}, cw_data_o, 64'h3E8);
        checkOutput({pfx, "_code"}, 64'(cw_code_o), 64'd9);
        checkOutput({pfx, "_flush"}, 64'(cw_flush_o), 64'd0);
        @(negedge clk_i);
        checkOutput({pfx, "_valid_after"}, 64'(cw_valid_o), 64'd0);
        checkOutput({pfx, "_slot9"}, 64'(dut.slot_cnt[9]), 64'd0);
        checkOutput({pfx, "_words"}, 64'(words - w0), 64'd1);
    endtask

    logic [6:0]  fl_len  [4];
    logic [63:0] fl_data [4];
    logic [3:0]  fl_code [4];
    logic        fl_flag [4];

    initial begin
        int nw;
        int n;
        int w0;
        int o0;
        logic done_seen;
        checks      = 0;
        failures    = 0;
        words       = 0;
        ovf_count   = 0;
        rst_i       = 1'b1;
        sym_valid_i = 1'b0;
        sym_data_i  = 4'd0;
        sym_code_i  = 4'd0;
        flush_i     = 1'b0;
        cw_ready_i  = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("rst_cw_valid", 64'(cw_valid_o), 64'd0);
        checkOutput("rst_cw_length", 64'(cw_length_o), 64'd0);
        checkOutput("rst_ovf", 64'(ovf_o), 64'd0);
        checkOutput("rst_flush_done", 64'(flush_done_o), 64'd0);
        checkOutput("rst_lk_cnt", 64'(lk_cnt_o), 64'd0);
        checkSlotsEmpty("rst_slots");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("idle_sym_ready", 64'(sym_ready_o), 64'd1);

        // Test 1: single terminal symbol matches immediately.
        $display("[TB] test 1");
        runTest1("t1");

        // Test 2: 0, 2, F into slot 9.
        $display("[TB] test 2");
        applyStimulus(4'd9, 4'h0);
        @(negedge clk_i);
        checkOutput("t2_lk_cnt1", 64'(lk_cnt_o), 64'd1);
        @(negedge clk_i);
        checkOutput("t2_no_cw_0", 64'(cw_valid_o), 64'd0);
        applyStimulus(4'd9, 4'h2);
        @(negedge clk_i);
        checkOutput("t2_lk_data2", lk_data_o, 64'h02);
        @(negedge clk_i);
        checkOutput("t2_no_cw_2", 64'(cw_valid_o), 64'd0);
        applyStimulus(4'd9, 4'hF);
        @(negedge clk_i);
        checkOutput("t2_lk_data3", lk_data_o, 64'h02F);
        @(negedge clk_i);
        checkOutput("t2_valid", 64'(cw_valid_o), 64'd1);
        checkOutput("t2_length", 64'(cw_length_o), 64'd15);
        checkOutput("t2_data", cw_data_o, 64'h7FF0);
        @(negedge clk_i);
        checkOutput("t2_slot9", 64'(dut.slot_cnt[9]), 64'd0);

        // Test 3: consumer stalls for 5 cycles.
        $display("[TB] test 3");
        w0 = words;
        cw_ready_i = 1'b0;
        applyStimulus(4'd9, 4'hF);
        @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checkOutput("t3_valid_hold", 64'(cw_valid_o), 64'd1);
            checkOutput("t3_length_hold", 64'(cw_length_o), 64'd10);
            checkOutput("t3_data_hold", cw_data_o, 64'h3E8);
            checkOutput("t3_sym_ready", 64'(sym_ready_o), 64'd0);
        end
        @(posedge clk_i);
        #1;
        cw_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t3_valid_last", 64'(cw_valid_o), 64'd1);
        @(negedge clk_i);
        checkOutput("t3_valid_after", 64'(cw_valid_o), 64'd0);
        checkOutput("t3_words", 64'(words - w0), 64'd1);

        // Test 4: sixteen misses into slot 4 overflow once.
        $display("[TB] test 4");
        o0 = ovf_count;
        w0 = words;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(4'd4, 4'h0);
            @(negedge clk_i);
            @(negedge clk_i);
        end
        checkOutput("t4_no_ovf_yet", 64'(ovf_count - o0), 64'd0);
        checkOutput("t4_cnt15", 64'(dut.slot_cnt[4]), 64'd15);
        applyStimulus(4'd4, 4'h0);
        @(negedge clk_i);
        checkOutput("t4_lk_cnt16", 64'(lk_cnt_o), 64'd16);
        @(negedge clk_i);
        checkOutput("t4_ovf_pulse", 64'(ovf_o), 64'd1);
        @(negedge clk_i);
        checkOutput("t4_ovf_low", 64'(ovf_o), 64'd0);
        checkOutput("t4_ovf_count", 64'(ovf_count - o0), 64'd1);
        checkOutput("t4_cnt0", 64'(dut.slot_cnt[4]), 64'd0);
        checkOutput("t4_no_words", 64'(words - w0), 64'd0);

        // Test 5: flush two non-empty slots.
        $display("[TB] test 5");
        applyStimulus(4'd3, 4'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        applyStimulus(4'd3, 4'h1);
        @(negedge clk_i);
        @(negedge clk_i);
        applyStimulus(4'd7, 4'h2);
        @(negedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        nw = 0;
        done_seen = 1'b0;
        for (int i = 0; i < 80 && !done_seen; i++) begin
            @(negedge clk_i);
            if (cw_valid_o && cw_ready_i && nw < 4) begin
                fl_len[nw]  = cw_length_o;
                fl_data[nw] = cw_data_o;
                fl_code[nw] = cw_code_o;
                fl_flag[nw] = cw_flush_o;
                nw++;
            end
            if (flush_done_o) done_seen = 1'b1;
        end
        checkOutput("t5_done_seen", 64'(done_seen), 64'd1);
        checkOutput("t5_nwords", 64'(nw), 64'd2);
        if (nw >= 2) begin
            checkOutput("t5_w0_len", 64'(fl_len[0]), 64'd8);
            checkOutput("t5_w0_data", fl_data[0], 64'h01);
            checkOutput("t5_w0_code", 64'(fl_code[0]), 64'd3);
            checkOutput("t5_w0_flush", 64'(fl_flag[0]), 64'd1);
            checkOutput("t5_w1_len", 64'(fl_len[1]), 64'd4);
            checkOutput("t5_w1_data", fl_data[1], 64'h2);
            checkOutput("t5_w1_code", 64'(fl_code[1]), 64'd7);
            checkOutput("t5_w1_flush", 64'(fl_flag[1]), 64'd1);
        end
        @(negedge clk_i);
        checkSlotsEmpty("t5_slots_empty");

        // Flush with every slot empty finishes NUM_CODES cycles after sampling.
        $display("[TB] test 5b");
        @(posedge clk_i);
        #1;
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        n = 0;
        done_seen = 1'b0;
        while (!done_seen && n < 40) begin
            @(negedge clk_i);
            n++;
            if (flush_done_o) done_seen = 1'b1;
        end
        checkOutput("t5b_done_cycle", 64'(n), 64'd16);
        @(negedge clk_i);
        checkOutput("t5b_done_pulse", 64'(flush_done_o), 64'd0);

        // Test 6: reset while a codeword is pending.
        $display("[TB] test 6");
        applyStimulus(4'd3, 4'h5);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t6_slot3_loaded", 64'(dut.slot_cnt[3]), 64'd1);
        @(posedge clk_i);
        #1;
        cw_ready_i = 1'b0;
        applyStimulus(4'd9, 4'hF);
        @(negedge clk_i);
        @(negedge clk_i);
        checkOutput("t6_emit_valid", 64'(cw_valid_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        cw_ready_i = 1'b1;
        @(negedge clk_i);
        checkOutput("t6_valid_cleared", 64'(cw_valid_o), 64'd0);
        checkSlotsEmpty("t6_slots_empty");
        runTest1("t6_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the directed sequence stalls somewhere unbounded.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
